// File: rtl/resp_misr_compactor.sv
`default_nettype none
// ============================================================================
// Module   : resp_misr_compactor
// Brief    : Compacts a wide response bus into a MISR signature, one per run.
//            The bus is sampled on every in_valid cycle, after a fixed warm-up.
//            Optional feature macro: RESP_COMPARE_EN. It registers a compare
//            of the final signature against exp_sig, which is sampled at start.
// Revision : 1.0 - initial release
// ============================================================================
module resp_misr_compactor #(
    parameter int                DATA_W = 330,
    parameter int                SIG_W  = 32,
    parameter int                CNT_W  = 16,
    parameter int                WARMUP = 2,
    parameter logic [SIG_W-1:0]  POLY   = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]  SEED   = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_cycles,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] resp_data,
    input  logic [SIG_W-1:0]  exp_sig,
    output logic              busy,
    output logic              sig_valid,
    input  logic              sig_ready,
    output logic [SIG_W-1:0]  sig,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              match
);

    localparam int               C_NCHUNK  = (DATA_W + SIG_W - 1) / SIG_W;
    localparam int               C_PAD_W   = C_NCHUNK * SIG_W;
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_WARMUP  = CNT_W'(WARMUP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cycles;
    logic [CNT_W-1:0]   r_warm_cnt;
    logic [C_PAD_W-1:0] w_padded;
    logic [SIG_W-1:0]   w_fold;
    logic [SIG_W-1:0]   w_step;
    logic               w_accept;
    logic               w_warm_tick;
    logic               w_absorb;

    // Zero-pad the bus to a whole number of signature-wide chunks
    assign w_padded = C_PAD_W'(resp_data);

    // XOR all chunks together into one signature-wide word
    always_comb begin
        w_fold = '0;
        for (int k = 0; k < C_NCHUNK; k++) begin
            w_fold = w_fold ^ w_padded[k*SIG_W +: SIG_W];
        end
    end

    assign w_step = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ w_fold;

    assign busy      = (r_state != S_IDLE);
    assign sig_valid = (r_state == S_DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and datapath enables; abort overrides everything
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_warm_tick = 1'b0;
        w_absorb    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (cfg_cycles == '0) begin
                        w_next = S_DONE;
                    end else if (WARMUP > 0) begin
                        w_next = S_WARMUP;
                    end else begin
                        w_next = S_RUN;
                    end
                end
            end
            S_WARMUP: begin
                if (in_valid) begin
                    w_warm_tick = 1'b1;
                    if (r_warm_cnt <= C_ONE) begin
                        w_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    w_absorb = 1'b1;
                    // r_cycles is nonzero here: a zero-length run skips RUN
                    if (sample_cnt >= (r_cycles - C_ONE)) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (sig_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (abort) begin
            w_next      = S_IDLE;
            w_accept    = 1'b0;
            w_warm_tick = 1'b0;
            w_absorb    = 1'b0;
        end
    end

    // Signature, counters and run-length latch; values persist after abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig        <= SEED;
            sample_cnt <= '0;
            r_warm_cnt <= '0;
            r_cycles   <= '0;
        end else begin
            if (w_accept) begin
                sig        <= SEED;
                sample_cnt <= '0;
                r_cycles   <= cfg_cycles;
                r_warm_cnt <= C_WARMUP;
            end
            if (w_warm_tick) begin
                r_warm_cnt <= r_warm_cnt - C_ONE;
            end
            if (w_absorb) begin
                sig <= w_step;
                if (sample_cnt != C_CNT_MAX) begin
                    sample_cnt <= sample_cnt + C_ONE;
                end
            end
        end
    end

`ifdef RESP_COMPARE_EN
    logic [SIG_W-1:0] r_exp;
    logic             r_match;

    // Expected signature captured with the run; compare resolved on DONE entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp   <= '0;
            r_match <= 1'b0;
        end else begin
            if (w_accept) begin
                r_exp <= exp_sig;
            end
            if ((w_next == S_DONE) && (r_state != S_DONE)) begin
                r_match <= w_accept ? (SEED == exp_sig) : (w_step == r_exp);
            end else if (w_next != S_DONE) begin
                r_match <= 1'b0;
            end
        end
    end

    assign match = r_match & sig_valid;
`else
    logic w_unused_exp;
    assign w_unused_exp = ^exp_sig;
    assign match        = 1'b0;
`endif

endmodule
`default_nettype wire
